seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 4-bit combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, and holds the carry between chunks in a register.
- Uses a start/busy/done handshake and reports signed overflow.
- Used in the datapath where a wide full-width carry chain would limit timing or area.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle. Range 1..WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk    input   1      system clock, rising edge
- rst    input   1      asynchronous, active-high reset
- start  input   1      request a new operation; sampled only in IDLE
- sub    input   1      0: a+b+cin; 1: a-b (cin ignored)
- cin    input   1      carry-in for addition
- a      input   WIDTH  operand A
- b      input   WIDTH  operand B
- busy   output  1      high in RUN and DONE states
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  result
- cout   output  1      carry out of MSB. For subtraction, 1 = no borrow (a >= b unsigned)
- ovf    output  1      two's-complement signed overflow

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-operation):
  - state = IDLE, chunk counter = 0.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start = 1 at a clock edge. At that edge:
    - latch a_r = a and b_r = (sub ? ~b : b).
    - load the carry register with (sub ? 1 : cin).
    - set counter = 0.
  - RUN: each edge computes chunk k = counter over bits [k*CHUNK +: CHUNK]:
    - {c, s} = a_r[chunk] + b_r[chunk] + carry.
    - write s into sum[chunk] and store c in the carry register.
    - increment counter.
  - RUN -> DONE on the edge that processes chunk NCHUNK-1. On that edge:
    - cout = final carry.
    - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed inside the last chunk.
  - DONE: done = 1 for exactly one cycle. DONE -> IDLE unconditionally at the next edge.
- Latency: done is high in the cycle following the NCHUNK-th edge after the accepting edge. With CHUNK = WIDTH, done follows 1 edge after acceptance.
- Throughput: one operation per NCHUNK+2 cycles. start is accepted only in IDLE.
- Start while busy: start in RUN or DONE is ignored. Operands are not re-latched and the result is unaffected.
- Operand stability: a, b, sub and cin may change freely after the accepting edge. Only the latched copies are used.
- Output timing:
  - sum bits for processed chunks update during RUN. sum is valid only when done = 1.
  - sum, cout and ovf then hold their values until the next accepted start.
  - cout and ovf do not change during RUN until the final chunk.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x1234+0x4321, cin=0:
  - sum = 0x5555, cout = 0, ovf = 0.
  - done rises 4 edges after accept, high for exactly 1 cycle; busy high in RUN and DONE.
- Add 0xFFFF+0x0001, cin=0 (carry ripples through all chunks) -> sum = 0x0000, cout = 1, ovf = 0.
- Add 0x7FFF+0x0001 -> sum = 0x8000, cout = 0, ovf = 1.
- Add 0x0000+0x0000, cin=1 -> sum = 0x0001, cout = 0, ovf = 0.
- Subtract, sub=1:
  - 0x0005-0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0.
  - 0x8000-0x0001 -> sum = 0x7FFF, cout = 1, ovf = 1.
- Start 0x1111+0x2222, then pulse start with 0xFFFF+0xFFFF during RUN:
  - second request is ignored; result is sum = 0x3333, cout = 0.
  - a fresh start issued in IDLE afterwards is accepted normally.
- Assert rst mid-RUN, asynchronously between edges:
  - all outputs go to 0 immediately and state = IDLE; no done pulse.
  - the next operation 0x00FF+0x0001 gives sum = 0x0100.
- Repeat the add scenarios with CHUNK=16 (done 1 edge after accept) and CHUNK=1 (done 16 edges after accept). Results must be identical.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for the chunked adder/subtractor.
// The master drives the request and the slave returns the result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock and keeps the
// inter-chunk carry in a register, with start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [BW-1:0]    w_base;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK:0]   w_chunkSum;
  logic             w_carryIntoMsb;

  assign w_base     = BW'(int'(r_cnt) * CHUNK);
  assign w_aChunk   = r_a[w_base +: CHUNK];
  assign w_bChunk   = r_b[w_base +: CHUNK];
  assign w_chunkSum = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
  // Sum bit is a^b^carry_in, so the carry into the chunk MSB falls out of an XOR.
  assign w_carryIntoMsb = w_chunkSum[CHUNK-1] ^ w_aChunk[CHUNK-1] ^ w_bChunk[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_chunkSum[CHUNK-1:0];
          r_carry                <= w_chunkSum[CHUNK];
          r_cnt                  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout  <= w_chunkSum[CHUNK];
            r_ovf   <= w_carryIntoMsb ^ w_chunkSum[CHUNK];
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: three instances (CHUNK 4, 16, 1)
// see identical stimulus and are checked against hand-computed results.
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  int checks = 0;
  int errors = 0;
  int nch[3];

  logic        obsBusy[3];
  logic        obsDone[3];
  logic        obsCout[3];
  logic        obsOvf[3];
  logic [15:0] obsSum[3];

  typedef struct {
    string       name;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOvf;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) ifA ();
  seq_chunk_adder_if #(.WIDTH(16)) ifB ();
  seq_chunk_adder_if #(.WIDTH(16)) ifC ();

  assign ifA.start = start; assign ifA.sub = sub; assign ifA.cin = cin; assign ifA.a = a; assign ifA.b = b;
  assign ifB.start = start; assign ifB.sub = sub; assign ifB.cin = cin; assign ifB.a = a; assign ifB.b = b;
  assign ifC.start = start; assign ifC.sub = sub; assign ifC.cin = cin; assign ifC.a = a; assign ifC.b = b;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dutA (.clk(clk), .rst(rst), .bus(ifA));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dutC (.clk(clk), .rst(rst), .bus(ifC));

  task automatic sampleAll();
    obsBusy[0] = ifA.busy; obsDone[0] = ifA.done; obsSum[0] = ifA.sum; obsCout[0] = ifA.cout; obsOvf[0] = ifA.ovf;
    obsBusy[1] = ifB.busy; obsDone[1] = ifB.done; obsSum[1] = ifB.sum; obsCout[1] = ifB.cout; obsOvf[1] = ifB.ovf;
    obsBusy[2] = ifC.busy; obsDone[2] = ifC.done; obsSum[2] = ifC.sum; obsCout[2] = ifC.cout; obsOvf[2] = ifC.ovf;
  endtask

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (chunk=%0d): got 0x%0h, expected 0x%0h", name, 16 / nch[inst], act, exp);
    end
  endtask

  task automatic checkAllZero(input string name);
    sampleAll();
    for (int i = 0; i < 3; i++) begin
      checkOutput({name, "/busy"}, i, 32'(obsBusy[i]), 32'd0);
      checkOutput({name, "/done"}, i, 32'(obsDone[i]), 32'd0);
      checkOutput({name, "/sum"},  i, 32'(obsSum[i]),  32'd0);
      checkOutput({name, "/cout"}, i, 32'(obsCout[i]), 32'd0);
      checkOutput({name, "/ovf"},  i, 32'(obsOvf[i]),  32'd0);
    end
  endtask

  // With poke set, start stays high for two more edges carrying junk operands.
  task automatic applyStimulus(input vec_t v, input bit poke);
    int          doneCyc[3];
    int          doneCnt[3];
    logic [15:0] capSum[3];
    logic        capCout[3];
    logic        capOvf[3];
    for (int i = 0; i < 3; i++) begin
      doneCyc[i] = -1; doneCnt[i] = 0; capSum[i] = '0; capCout[i] = 1'b0; capOvf[i] = 1'b0;
    end
    @(negedge clk);
    sub = v.sub; cin = v.cin; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    sampleAll();
    for (int i = 0; i < 3; i++) checkOutput({v.name, "/busy_accept"}, i, 32'(obsBusy[i]), 32'd1);
    if (poke) begin
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1;
    end else begin
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    end
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2) start = 1'b0;
      sampleAll();
      for (int i = 0; i < 3; i++) begin
        if (obsDone[i]) begin
          doneCnt[i]++;
          if (doneCyc[i] < 0) begin
            doneCyc[i] = cyc; capSum[i] = obsSum[i]; capCout[i] = obsCout[i]; capOvf[i] = obsOvf[i];
          end
        end
        if (cyc == nch[i])     checkOutput({v.name, "/busy_done"}, i, 32'(obsBusy[i]), 32'd1);
        if (cyc == nch[i] + 1) checkOutput({v.name, "/busy_idle"}, i, 32'(obsBusy[i]), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput({v.name, "/latency"},   i, 32'(doneCyc[i]), 32'(nch[i]));
      checkOutput({v.name, "/done_count"}, i, 32'(doneCnt[i]), 32'd1);
      checkOutput({v.name, "/sum"},        i, 32'(capSum[i]),  32'(v.expSum));
      checkOutput({v.name, "/cout"},       i, 32'(capCout[i]), 32'(v.expCout));
      checkOutput({v.name, "/ovf"},        i, 32'(capOvf[i]),  32'(v.expOvf));
    end
  endtask

  initial begin
    vec_t pokeVec;
    vec_t postRst;
    int   spurious;

    nch[0] = 4; nch[1] = 1; nch[2] = 16;
    vecs[0] = '{"add_basic",    1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple",   1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_ovf",      1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"add_cin",      1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{"sub_borrow",   1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{"sub_ovf",      1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{"sub_cin_ign",  1'b1, 1'b1, 16'h0010, 16'h0010, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"add_neg_ovf",  1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{"add_mixed",    1'b0, 1'b0, 16'hABCD, 16'h1234, 16'hBE01, 1'b0, 1'b0};
    vecs[9] = '{"sub_pos_neg",  1'b1, 1'b0, 16'h0001, 16'h8000, 16'h8001, 1'b0, 1'b1};
    pokeVec = '{"start_busy",   1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0};
    postRst = '{"after_reset",  1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};

    $display("[TB] starting seq_chunk_adder bench");
    #12;
    checkAllZero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) applyStimulus(vecs[k], 1'b0);

    applyStimulus(pokeVec, 1'b1);
    applyStimulus(vecs[0], 1'b0);

    // Reset lands between edges while the CHUNK=4 and CHUNK=1 instances are mid-RUN.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      sampleAll();
      for (int i = 0; i < 3; i++) if (obsDone[i] || obsBusy[i]) spurious++;
    end
    checkOutput("no_activity_after_reset", 0, 32'(spurious), 32'd0);
    applyStimulus(postRst, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
